// File: rtl/fu_mult_pool.sv
// Pool of iterative shift-add multiplier lanes with round-robin writeback.
// Optional feature: define MUL_ZERO_SKIP_EN to complete zero-operand operations immediately.
module fu_mult_pool #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [1:0]           issue_op,
  input  logic [XLEN-1:0]      issue_a,
  input  logic [XLEN-1:0]      issue_b,
  input  logic [TAG_W-1:0]     issue_tag,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [XLEN-1:0]      wb_data,
  output logic [TAG_W-1:0]     wb_tag,
  output logic [XLEN-1:0]      wb_a,
  output logic [XLEN-1:0]      wb_b,
  output logic [NUM_LANES-1:0] lane_busy
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [1:0]  OP_MUL    = 2'd0;
  localparam logic [1:0]  OP_MULH   = 2'd1;
  localparam logic [1:0]  OP_MULHSU = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} lane_st_e;

  lane_st_e             st     [NUM_LANES];
  logic [CNT_W-1:0]     cnt    [NUM_LANES];
  logic [1:0]           op_q   [NUM_LANES];
  logic [XLEN-1:0]      a_q    [NUM_LANES];
  logic [XLEN-1:0]      b_q    [NUM_LANES];
  logic [TAG_W-1:0]     tag_q  [NUM_LANES];
  logic [PW-1:0]        mcand  [NUM_LANES];
  logic [XLEN-1:0]      mplier [NUM_LANES];
  logic [PW-1:0]        prod   [NUM_LANES];
  logic [PW-1:0]        sum    [NUM_LANES];
  logic [NUM_LANES-1:0] neg_q;

  logic [IDX_W-1:0] rr_ptr, held_idx, grant, issue_idx, rr_idx;
  logic             hold, any_idle, any_done, accept, wb_fire;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;

  // Operand magnitudes; the sign is reapplied to the full product at the end.
  always_comb begin
    a_neg = ((issue_op == OP_MULH) || (issue_op == OP_MULHSU)) && issue_a[XLEN-1];
    b_neg = (issue_op == OP_MULH) && issue_b[XLEN-1];
    a_mag = a_neg ? ('0 - issue_a) : issue_a;
    b_mag = b_neg ? ('0 - issue_b) : issue_b;
  end

  // Lowest-index idle lane for issue, and first done lane at or after rr_ptr.
  always_comb begin
    int j;
    j         = 0;
    any_idle  = 1'b0;
    issue_idx = '0;
    any_done  = 1'b0;
    rr_idx    = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (st[i] == IDLE) begin
        any_idle  = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % int'(NUM_LANES);
      if (st[j] == DONE) begin
        any_done = 1'b1;
        rr_idx   = IDX_W'(j);
      end
    end
  end

  assign grant       = hold ? held_idx : rr_idx;
  assign wb_valid    = (hold || any_done) && !flush;
  assign issue_ready = any_idle && !flush;
  assign accept      = issue_valid && issue_ready;
  assign wb_fire     = wb_valid && wb_ready;

  always_comb begin
    wb_data   = '0;
    wb_tag    = '0;
    wb_a      = '0;
    wb_b      = '0;
    lane_busy = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_busy[i] = (st[i] != IDLE);
      sum[i]       = prod[i] + (mplier[i][0] ? mcand[i] : '0);
    end
    if (wb_valid) begin
      wb_data = (op_q[grant] == OP_MUL) ? prod[grant][XLEN-1:0] : prod[grant][PW-1:XLEN];
      wb_tag  = tag_q[grant];
      wb_a    = a_q[grant];
      wb_b    = b_q[grant];
    end
  end

  // Per-lane state machine and shift-add datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        st[i]     <= IDLE;
        cnt[i]    <= '0;
        op_q[i]   <= '0;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        tag_q[i]  <= '0;
        mcand[i]  <= '0;
        mplier[i] <= '0;
        prod[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (flush) begin
          st[i]  <= IDLE;
          cnt[i] <= '0;
        end else begin
          case (st[i])
            IDLE: begin
              if (accept && (issue_idx == IDX_W'(i))) begin
                op_q[i]   <= issue_op;
                a_q[i]    <= issue_a;
                b_q[i]    <= issue_b;
                tag_q[i]  <= issue_tag;
                mcand[i]  <= PW'(a_mag);
                mplier[i] <= b_mag;
                prod[i]   <= '0;
                neg_q[i]  <= a_neg ^ b_neg;
                cnt[i]    <= '0;
`ifdef MUL_ZERO_SKIP_EN
                st[i]     <= ((issue_a == '0) || (issue_b == '0)) ? DONE : CALC;
`else
                st[i]     <= CALC;
`endif
              end
            end
            CALC: begin
              mcand[i]  <= mcand[i] << 1;
              mplier[i] <= mplier[i] >> 1;
              cnt[i]    <= cnt[i] + CNT_W'(1);
              if (cnt[i] == CNT_W'(XLEN - 1)) begin
                st[i]   <= DONE;
                prod[i] <= neg_q[i] ? ('0 - sum[i]) : sum[i];
              end else begin
                prod[i] <= sum[i];
              end
            end
            DONE: begin
              if (wb_fire && (grant == IDX_W'(i))) st[i] <= IDLE;
            end
            default: st[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Round-robin pointer and grant lock while writeback is back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      hold     <= 1'b0;
      held_idx <= '0;
    end else if (flush) begin
      hold <= 1'b0;
    end else if (wb_fire) begin
      hold   <= 1'b0;
      rr_ptr <= (grant == IDX_W'(NUM_LANES - 1)) ? '0 : grant + IDX_W'(1);
    end else if (wb_valid) begin
      hold     <= 1'b1;
      held_idx <= grant;
    end
  end

endmodule

// File: doc/fu_mult_pool.md
FU_MULT_POOL -- requirements
Module: fu_mult_pool

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, number of independent iterative multiplier lanes (1..8).
REQ-002 SHALL have parameter XLEN, default 32, operand and result width.
REQ-003 SHALL have parameter TAG_W, default 5, width of the instruction tag carried with each operation.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  squash all in-flight and completed-but-unwritten operations.
REQ-007 SHALL have port issue_valid  input  1  issue request from reservation station.
REQ-008 SHALL have port issue_ready  output  1  pool can accept an operation this cycle.
REQ-009 SHALL have port issue_op  input  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
REQ-010 SHALL have ports issue_a, issue_b  input  XLEN  operands rs1, rs2.
REQ-011 SHALL have port issue_tag  input  TAG_W  tag returned with the result.
REQ-012 SHALL have port wb_valid  output  1  a result is presented for writeback.
REQ-013 SHALL have port wb_ready  input  1  writeback consumer accepts the presented result.
REQ-014 SHALL have ports wb_data  output  XLEN, wb_tag  output  TAG_W, wb_a, wb_b  output  XLEN  result, tag, original operands.
REQ-015 SHALL have port lane_busy  output  NUM_LANES  per-lane non-IDLE indicator.

Function
REQ-016 Each lane SHALL have states IDLE, CALC, DONE, with a cycle counter of width clog2(XLEN+1).
REQ-017 issue_ready SHALL equal (any lane IDLE) AND NOT flush, computed from registered lane state only.
REQ-018 Accept on issue_valid AND issue_ready; lowest-index IDLE lane SHALL capture op, operands, tag and enter CALC with counter 0.
REQ-019 CALC SHALL run exactly XLEN cycles; lane enters DONE at the XLEN-th rising edge after the accept edge.
REQ-020 MUL SHALL return product[XLEN-1:0]; MULH signed x signed, MULHSU signed a x unsigned b, MULHU unsigned x unsigned SHALL return product[2*XLEN-1:XLEN].
REQ-021 Signed operands SHALL be handled by magnitude multiply plus final conditional negate of the 2*XLEN product; MULH of most-negative x most-negative SHALL yield 2^(XLEN-2).
REQ-022 Writeback SHALL be round-robin over DONE lanes; pointer starts at lane 0 and advances to granted lane+1 (mod NUM_LANES) on each wb handshake.
REQ-023 While wb_valid AND NOT wb_ready, wb_data, wb_tag, wb_a, wb_b and the selected lane SHALL stay stable.
REQ-024 On wb handshake the granted lane SHALL return to IDLE at that edge; it SHALL NOT appear in issue_ready until the next cycle.
REQ-025 With wb_valid low, wb_data, wb_tag, wb_a, wb_b SHALL be 0.
REQ-026 flush SHALL force wb_valid and issue_ready low in the same cycle and set every lane IDLE at the next edge; issue_valid and wb_ready are ignored in that cycle.
REQ-027 Issue and writeback in the same cycle SHALL both complete; a full pool SHALL hold issue_ready low without dropping any result.

Reset
REQ-028 rst_n low SHALL asynchronously set all lanes IDLE, counters 0, RR pointer 0, all captured data 0.
REQ-029 During and after reset until the first issue: issue_ready=1, wb_valid=0, lane_busy=0, all wb data outputs 0.
REQ-030 Reset mid-CALC SHALL discard the operation with no result produced.

Configuration
REQ-031 Macro MUL_ZERO_SKIP_EN defined: an accepted operation with issue_a==0 or issue_b==0 SHALL go directly to DONE with result 0 at the accept edge+1.
REQ-032 Macro MUL_ZERO_SKIP_EN undefined: all operations SHALL take the full XLEN-cycle CALC of REQ-019.

Verification
REQ-033 Issue MULHU 0xFFFFFFFF x 0xFFFFFFFF, tag 3, wb_ready=1 -> wb_valid after 32 cycles, wb_data=0xFFFFFFFE, wb_tag=3.
REQ-034 Issue MULH 0x80000000 x 0x80000000, then MUL 7 x -3 -> results 0x40000000 then 0xFFFFFFEB, tags in issue order.
REQ-035 NUM_LANES=2, issue 3 ops back-to-back -> third stalls (issue_ready=0) until first wb handshake, then accepted next cycle.
REQ-036 Two lanes DONE, wb_ready low 5 cycles -> outputs stable 5 cycles; on release lane 0 then lane 1 written, pointer wraps to 0.
REQ-037 flush two cycles after issuing to both lanes -> wb_valid never asserts, lane_busy=0 next cycle, issue_ready=1.
REQ-038 MUL_ZERO_SKIP_EN defined, issue MUL 0 x 0x1234 -> wb_valid next cycle with wb_data=0; undefined -> after 32 cycles.
